// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types for the ALU execute stage.
//   alu_op_t    : 3-bit ALUControl encodings understood by alu_core.
//   alu_flags_t : packed {zero, negative, carry, overflow} flag bundle.
// Optional feature macro used elsewhere: ALU_SLT_EN (enables code 011 = SLT).
package alu_pkg;

  localparam int ALU_CODE_W = 3;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLT = 3'b011,
    ALU_SUB = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if
// Handshake and data bundle of the ALU execute stage.
//   Input side  : in_valid, in_ready, alu_control, src_a, src_b, in_tag
//   Output side : out_valid, out_ready, result, zero, negative, carry,
//                 overflow, out_tag
// Modports:
//   master : the environment (issues ops, consumes results)
//   slave  : the execute stage itself
interface alu_exec_stage_if
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [ALU_CODE_W-1:0] alu_control;
  logic [XLEN-1:0]       src_a;
  logic [XLEN-1:0]       src_b;
  logic [TAG_W-1:0]      in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       result;
  logic                  zero;
  logic                  negative;
  logic                  carry;
  logic                  overflow;
  logic [TAG_W-1:0]      out_tag;

  modport master (
    output in_valid, alu_control, src_a, src_b, in_tag, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow, out_tag
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, in_tag, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow, out_tag
  );

endinterface

// File: rtl/alu_core.sv
// alu_core
// Purely combinational ALU: op code + two operands -> result + flags.
// Ports:
//   op     in  3     ALUControl code
//   a, b   in  XLEN  operands
//   result out XLEN  ALU result (0 for unsupported codes)
//   flags  out       {zero, negative, carry, overflow}
// Optional feature: ALU_SLT_EN makes code 011 a signed set-less-than.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_CODE_W-1:0] op,
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  output logic [XLEN-1:0]       result,
  output alu_flags_t            flags
);

  logic            is_sub;
  logic [XLEN-1:0] and_bits;
  logic [XLEN-1:0] or_bits;
  logic [XLEN-1:0] xor_bits;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic            add_ovf;
  logic            sub_ovf;

  assign is_sub = (op == ALU_SUB);

  // Bitwise lanes; SUB reuses the adder with b inverted and carry-in 1.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
    assign and_bits[gi] = a[gi] & b[gi];
    assign or_bits[gi]  = a[gi] | b[gi];
    assign xor_bits[gi] = a[gi] ^ b[gi];
    assign b_eff[gi]    = is_sub ? ~b[gi] : b[gi];
  end

  assign sum = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};

  assign add_ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  assign sub_ovf = (a[XLEN-1] != b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

`ifdef ALU_SLT_EN
  logic slt_bit;
  assign slt_bit = ($signed(a) < $signed(b));
`endif

  always_comb begin
    result         = '0;
    flags          = '0;
    case (op)
      ALU_ADD: begin
        result         = sum[XLEN-1:0];
        flags.carry    = sum[XLEN];
        flags.overflow = add_ovf;
      end
      ALU_SUB: begin
        result         = sum[XLEN-1:0];
        flags.carry    = sum[XLEN];   // 1 = no borrow
        flags.overflow = sub_ovf;
      end
      ALU_AND: result = and_bits;
      ALU_OR:  result = or_bits;
      ALU_XOR: result = xor_bits;
`ifdef ALU_SLT_EN
      ALU_SLT: result = {{(XLEN-1){1'b0}}, slt_bit};
`endif
      default: result = '0;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[XLEN-1];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Registered ALU execute stage with valid/ready on both sides and a
// two-entry output buffer (output register + skid register). in_ready is
// taken straight from the skid-valid flop, so it never depends on out_ready.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears all buffered ops
//   bus    slave modport of alu_exec_stage_if (ops in, results/flags/tag out)
// Optional feature macro: ALU_SLT_EN (code 011 = SLT inside alu_core).
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_stage_if.slave bus
);

  logic [XLEN-1:0]  core_result;
  alu_flags_t       core_flags;

  logic             out_valid_reg;
  logic [XLEN-1:0]  out_result_reg;
  alu_flags_t       out_flags_reg;
  logic [TAG_W-1:0] out_tag_reg;

  logic             skid_valid_reg;
  logic [XLEN-1:0]  skid_result_reg;
  alu_flags_t       skid_flags_reg;
  logic [TAG_W-1:0] skid_tag_reg;

  logic             accept;
  logic             out_free;

  alu_core #(.XLEN(XLEN)) u_core (
    .op     (bus.alu_control),
    .a      (bus.src_a),
    .b      (bus.src_b),
    .result (core_result),
    .flags  (core_flags)
  );

  assign accept   = bus.in_valid && !skid_valid_reg;
  // Output register can be (re)loaded when empty or being taken this cycle.
  assign out_free = !out_valid_reg || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_result_reg  <= '0;
      out_flags_reg   <= '0;
      out_tag_reg     <= '0;
      skid_valid_reg  <= 1'b0;
      skid_result_reg <= '0;
      skid_flags_reg  <= '0;
      skid_tag_reg    <= '0;
    end else if (out_free) begin
      if (skid_valid_reg) begin
        // Skid drains first; in_ready is low so nothing is accepted now.
        out_valid_reg  <= 1'b1;
        out_result_reg <= skid_result_reg;
        out_flags_reg  <= skid_flags_reg;
        out_tag_reg    <= skid_tag_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg  <= 1'b1;
        out_result_reg <= core_result;
        out_flags_reg  <= core_flags;
        out_tag_reg    <= bus.in_tag;
      end else begin
        // Data is left in place; only the valid bit drops.
        out_valid_reg  <= 1'b0;
      end
    end else if (accept) begin
      // Output register stalled: park the new op in the skid register.
      skid_valid_reg  <= 1'b1;
      skid_result_reg <= core_result;
      skid_flags_reg  <= core_flags;
      skid_tag_reg    <= bus.in_tag;
    end
  end

  assign bus.in_ready  = !skid_valid_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = out_result_reg;
  assign bus.zero      = out_flags_reg.zero;
  assign bus.negative  = out_flags_reg.negative;
  assign bus.carry     = out_flags_reg.carry;
  assign bus.overflow  = out_flags_reg.overflow;
  assign bus.out_tag   = out_tag_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
// Directed testbench for alu_exec_stage. Inputs are driven 1 ns after the
// rising edge and outputs are sampled at that same point.
// Expected-value tables were worked out by hand for XLEN=32.
module tb_alu_exec_stage;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  alu_exec_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  alu_exec_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    logic [3:0]       zncv;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.in_tag      = tag;
  endtask

  task automatic test_reset();
    logic [XLEN+TAG_W+5:0] got;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_control = 3'b000;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.in_tag = '0;
    repeat (2) step();
    reset = 1'b0;
    got = {bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.negative,
           bus.carry, bus.overflow, bus.out_tag};
    vectors++;
    if (got !== {1'b0, 1'b1, {XLEN{1'b0}}, 4'b0000, {TAG_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", got,
               {1'b0, 1'b1, {XLEN{1'b0}}, 4'b0000, {TAG_W{1'b0}}});
    end
  endtask

  // Each op is issued alone with out_ready=1 and checked the next cycle.
  task automatic run_table(input string name, input vec_t tbl[]);
    logic [XLEN+TAG_W+4:0] got;
    logic [XLEN+TAG_W+4:0] exp;
    bus.out_ready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
      step();
      bus.in_valid = 1'b0;
      got = {bus.out_valid, bus.result, bus.zero, bus.negative, bus.carry,
             bus.overflow, bus.out_tag};
      exp = {1'b1, tbl[i].res, tbl[i].zncv, tbl[i].tag};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s[%0d] op=%b: got v/res/zncv/tag %h want %h",
                 name, i, tbl[i].op, got, exp);
      end
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s[%0d]_drained: out_valid got %b want 0", name, i,
                 bus.out_valid);
      end
    end
  endtask

  task automatic test_add();
    vec_t t[] = '{
      '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3,  32'h8000_0000, 4'b0101},
      '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4,  32'h0000_0000, 4'b1010}
    };
    run_table("add", t);
  endtask

  task automatic test_sub();
    vec_t t[] = '{
      '{3'b110, 32'h0000_0005, 32'h0000_0005, 5'd5,  32'h0000_0000, 4'b1010},
      '{3'b110, 32'h0000_0000, 32'h0000_0001, 5'd6,  32'hFFFF_FFFF, 4'b0100},
      '{3'b110, 32'h8000_0000, 32'h0000_0001, 5'd7,  32'h7FFF_FFFF, 4'b0011}
    };
    run_table("sub", t);
  endtask

  task automatic test_logic();
    vec_t t[] = '{
      '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8,  32'hF000_F000, 4'b0100},
      '{3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9,  32'hFFF0_FFF0, 4'b0100},
      '{3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 32'h0FF0_0FF0, 4'b0000}
    };
    run_table("logic", t);
  endtask

  task automatic test_undefined();
    vec_t t[] = '{
      '{3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 32'h0000_0000, 4'b1000},
      '{3'b101, 32'h7FFF_FFFF, 32'h0000_0001, 5'd12, 32'h0000_0000, 4'b1000}
    };
    run_table("undef", t);
  endtask

  task automatic test_slt();
`ifdef ALU_SLT_EN
    vec_t t[] = '{
      '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd13, 32'h0000_0001, 4'b0000},
      '{3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 4'b1000}
    };
`else
    vec_t t[] = '{
      '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd13, 32'h0000_0000, 4'b1000},
      '{3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 4'b1000}
    };
`endif
    run_table("slt", t);
  endtask

  // Four ADDs (i + 10) in consecutive cycles; each result appears the cycle
  // after it is offered while the next op is already being driven.
  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(3'b010, 32'(i), 32'd10, 5'(16 + i));
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      step();
      vectors++;
      if ({bus.out_valid, bus.result, bus.out_tag} !== {1'b1, 32'(i + 10), 5'(16 + i)}) begin
        miscompares++;
        $display("FAIL b2b_result[%0d]: got v=%b res=%h tag=%0d want v=1 res=%h tag=%0d",
                 i, bus.out_valid, bus.result, bus.out_tag, 32'(i + 10), 16 + i);
      end
    end
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  // A: SUB 100-1 = 99, B: XOR 0xFF^0x0F = 0xF0, C: OR 1|2 = 3.
  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive(3'b110, 32'd100, 32'd1, 5'd7);
    step();
    drive(3'b111, 32'h0000_00FF, 32'h0000_000F, 5'd8);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_in_ready_2nd: got %b want 1", bus.in_ready);
    end
    step();
    drive(3'b001, 32'd1, 32'd2, 5'd9);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_skid_full: in_ready got %b want 0", bus.in_ready);
    end
    repeat (2) step();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.out_tag} !==
        {1'b1, 1'b0, 32'd99, 1'b1, 5'd7}) begin
      miscompares++;
      $display("FAIL stall_hold: got v=%b rdy=%b res=%h c=%b tag=%0d want v=1 rdy=0 res=00000063 c=1 tag=7",
               bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.out_tag} !==
        {1'b1, 1'b1, 32'h0000_00F0, 5'd8}) begin
      miscompares++;
      $display("FAIL stall_skid_drain: got v=%b rdy=%b res=%h tag=%0d want v=1 rdy=1 res=000000f0 tag=8",
               bus.out_valid, bus.in_ready, bus.result, bus.out_tag);
    end
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.result, bus.out_tag} !== {1'b1, 32'd3, 5'd9}) begin
      miscompares++;
      $display("FAIL stall_third: got v=%b res=%h tag=%0d want v=1 res=00000003 tag=9",
               bus.out_valid, bus.result, bus.out_tag);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_no_dup: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_stall();
    bus.out_ready = 1'b0;
    drive(3'b010, 32'd1, 32'd1, 5'd21);
    step();
    drive(3'b010, 32'd2, 32'd2, 5'd22);
    step();
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_stall_setup: v/rdy got %b want 10", {bus.out_valid, bus.in_ready});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.negative,
         bus.carry, bus.overflow, bus.out_tag} !==
        {1'b1 ^ 1'b1, 1'b1, {XLEN{1'b0}}, 4'b0000, {TAG_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL rst_stall_clear: got v=%b rdy=%b res=%h zncv=%b tag=%0d want v=0 rdy=1 res=0 zncv=0000 tag=0",
               bus.out_valid, bus.in_ready, bus.result,
               {bus.zero, bus.negative, bus.carry, bus.overflow}, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall_discard: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_undefined();
    test_back_to_back();
    test_stall();
    test_reset_stall();
    test_slt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered ALU execute stage, directly downstream of the ALU control unit: consumes the 3-bit ALUControl code plus two operands, produces result and flags.
- Valid/ready handshake on both sides, one-cycle latency, 2-entry output buffering (output register plus skid register) so that in_ready is driven from a register.
- Feeds writeback/branch logic. The tag is passed through untouched, e.g. rd index.

Parameters:
- XLEN, 32, operand/result width (>=2)
- TAG_W, 5, width of pass-through tag

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept; registered (equals NOT skid_valid)
- alu_control  in  3  ALUControl code
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B
- in_tag  in  TAG_W  pass-through tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- result  out  XLEN  ALU result
- zero  out  1  result == 0
- negative  out  1  result[XLEN-1]
- carry  out  1  adder carry-out (ADD/SUB only, else 0)
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Codes:
  - 010 ADD a+b
  - 110 SUB a+~b+1; carry=1 means no borrow
  - 000 AND
  - 001 OR
  - 111 XOR
  - 011/100/101: result 0, carry 0, overflow 0. Still a valid transaction.
- Overflow: ADD = (a_msb==b_msb)&&(r_msb!=a_msb). SUB = (a_msb!=b_msb)&&(r_msb!=a_msb).
- zero and negative are computed from the final result for every code.
- Accept: in_valid && in_ready. Output: out_valid && out_ready.
- Latency: an accepted op appears on the outputs the next cycle when the output register is free or draining.
- Output register load priority:
  - (1) skid contents, when skid_valid and (!out_valid || out_ready);
  - (2) else the accepted input, when !out_valid || out_ready;
  - (3) else the accepted input goes to skid (skid_valid<=1).
- Skid drains into the output register on the first cycle out_ready=1. in_ready=0 while skid_valid=1, so no input is accepted that cycle.
- Simultaneous accept and output with skid empty: the new op replaces the output register, no bubble. Sustained throughput is 1 op/cycle.
- out_valid must hold, with result/flags/out_tag stable, until taken. Inputs are don't-care when in_valid=0.
- Reset (synchronous, any cycle, including mid-stall):
  - out_valid=0, skid_valid=0, in_ready=1
  - result=0, flags=0, out_tag=0
  - any in-flight/buffered ops are discarded.
- Arithmetic is modulo 2^XLEN. Carry is bit XLEN of the (XLEN+1)-bit sum.

Optional Feature:
- ALU_SLT_EN defined: code 011 = SLT, result = {0…,1} if signed(a)<signed(b) else 0. carry/overflow are 0 for SLT; zero/negative are derived from the result.
- Not defined: 011 behaves as the other undefined codes (result 0).

Decomposition:
- alu_pkg:
  - typedef enum logic [2:0] alu_op_t (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SLT=011, ALU_SUB=110, ALU_XOR=111)
  - struct alu_flags_t {zero, negative, carry, overflow}
- One sub-module, alu_core: purely combinational op/operands -> result + flags, parameterised by XLEN.
- alu_exec_stage instantiates alu_core and holds the output/skid registers and handshake.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle result 0x80000000, negative=1, overflow=1, carry=0, zero=0, tag echoed.
- SUB 5-5 -> result 0, zero=1, carry=1, overflow=0. SUB 0-1 -> 0xFFFFFFFF, carry=0, negative=1.
- AND/OR/XOR with 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0. Code 100 -> result 0.
- Back-to-back 4 ops with out_ready=1 -> 4 results on 4 consecutive cycles, order kept, in_ready stays 1.
- Hold out_ready=0 and offer 3 ops:
  - 2 accepted, 3rd blocked (in_ready=0 after the 2nd);
  - then out_ready=1 -> results appear in order, no loss or duplication, in_ready returns to 1 after the skid drains.
- Assert reset while stalled with skid full -> next cycle out_valid=0, in_ready=1, outputs 0. With ALU_SLT_EN, code 011 on -1,1 -> result 1; without it -> 0.
